instr_encoder: RTL and testbench

- Inverse of the instruction decoder: takes decoded RV64IM fields and assembles the 32-bit instruction word.
- Used by the self-check bench and the trace-replay path to regenerate instruction words from field records. Decoder round-trip checks compare against the original word.
- Two-stage valid/ready pipeline:
  - Stage 1 registers the fields.
  - Stage 2 range-checks the immediate and registers the assembled word.
- Throughput is one instruction per cycle.

---
 rtl/encoder_pkg.sv | 47 ++++
 rtl/imm_pack.sv | 60 ++++++
 rtl/instr_encoder.sv | 103 ++++++++++
 tb/tb_instr_encoder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared definitions for the RV64IM instruction encoder: opcodes, type codes,
// the stage-1 field record and the immediate range helper.
package encoder_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    // addi x0,x0,0 -- emitted whenever a record cannot be encoded
    localparam logic [31:0] NOP_WORD = 32'h00000013;

    localparam logic [3:0] TYPE_NO = 4'd0;
    localparam logic [3:0] TYPE_R  = 4'd1;
    localparam logic [3:0] TYPE_I  = 4'd2;
    localparam logic [3:0] TYPE_S  = 4'd3;
    localparam logic [3:0] TYPE_SB = 4'd4;
    localparam logic [3:0] TYPE_U  = 4'd5;
    localparam logic [3:0] TYPE_UJ = 4'd6;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [5:0]  shamt;
        logic [3:0]  itype;
    } enc_fields_t;

    // True when v, read as two's complement, fits in an nbits-wide signed field.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned nbits);
        logic signed [31:0] hi;
        hi = $signed(v) >>> (nbits - 1);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational assembly of one field record into a 32-bit RV64IM word,
// flagging immediates that the selected format cannot represent.
module imm_pack
    import encoder_pkg::*;
(
    input  enc_fields_t f,
    output logic [31:0] word,
    output logic        err
);

    logic [31:0] imm;
    logic        is_shift;

    assign imm      = f.imm;
    assign is_shift = ((f.opcode == OP_IMM) || (f.opcode == OP_IMM32)) &&
                      ((f.func3 == 3'b001) || (f.func3 == 3'b101));

    always_comb begin
        word = NOP_WORD;
        err  = 1'b0;
        case (f.itype)
            TYPE_R: begin
                word = {f.func7, f.rs2, f.rs1, f.func3, f.rd, f.opcode};
            end
            TYPE_I: begin
                if (is_shift) begin
                    // Word shifts only have a 5-bit shift amount
                    err  = (f.opcode == OP_IMM32) && f.shamt[5];
                    word = {f.func7[6:1], f.shamt, f.rs1, f.func3, f.rd, f.opcode};
                end else begin
                    err  = !fits_signed(imm, 12);
                    word = {imm[11:0], f.rs1, f.func3, f.rd, f.opcode};
                end
            end
            TYPE_S: begin
                err  = !fits_signed(imm, 12);
                word = {imm[11:5], f.rs2, f.rs1, f.func3, imm[4:0], f.opcode};
            end
            TYPE_SB: begin
                err  = !fits_signed(imm, 13) || imm[0];
                word = {imm[12], imm[10:5], f.rs2, f.rs1, f.func3, imm[4:1], imm[11], f.opcode};
            end
            TYPE_U: begin
                err  = (imm[11:0] != 12'd0);
                word = {imm[31:12], f.rd, f.opcode};
            end
            TYPE_UJ: begin
                err  = !fits_signed(imm, 21) || imm[0];
                word = {imm[20], imm[10:1], imm[11], imm[19:12], f.rd, f.opcode};
            end
            default: begin
                err = 1'b1;
            end
        endcase
        if (err) begin
            word = NOP_WORD;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready pipeline regenerating instruction words from decoded
// field records, with delivered-word and error counters.
module instr_encoder
    import encoder_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [31:0]      immediate,
    input  logic [5:0]       shamt,
    input  logic [3:0]       instr_type,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instruction,
    output logic             imm_err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    enc_fields_t fields_p1;
    logic        vld_p1;
    logic        vld_p2;
    logic [31:0] word_p2;
    logic        err_p2;
    logic        adv_p1;
    logic        adv_p2;
    logic [31:0] pack_word;
    logic        pack_err;

    assign adv_p2   = !vld_p2 || out_ready;
    assign adv_p1   = !vld_p1 || adv_p2;
    assign in_ready = adv_p1;

    // ---- stage 1: register the incoming field record ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else if (adv_p1) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv_p1 && in_valid) begin
            fields_p1.opcode <= opcode;
            fields_p1.func3  <= func3;
            fields_p1.func7  <= func7;
            fields_p1.rd     <= rd;
            fields_p1.rs1    <= rs1;
            fields_p1.rs2    <= rs2;
            fields_p1.imm    <= immediate;
            fields_p1.shamt  <= shamt;
            fields_p1.itype  <= instr_type;
        end
    end

    imm_pack u_imm_pack (
        .f    (fields_p1),
        .word (pack_word),
        .err  (pack_err)
    );

    // ---- stage 2: register the assembled word and its error flag ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p2  <= 1'b0;
            word_p2 <= '0;
            err_p2  <= 1'b0;
        end else if (adv_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                word_p2 <= pack_word;
                err_p2  <= pack_err;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (vld_p2 && out_ready) begin
            enc_count <= enc_count + CNT_W'(1);
            if (err_p2) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

    assign out_valid   = vld_p2;
    assign instruction = word_p2;
    assign imm_err     = err_p2;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: reset, latency, format assembly and range
// errors, back-to-back flow, back-pressure and mid-flight reset.
module tb_instr_encoder;
    import encoder_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] immediate;
    logic [5:0]  shamt;
    logic [3:0]  instr_type;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction;
    logic        imm_err;
    logic [31:0] enc_count;
    logic [31:0] err_count;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_enc = 0;
    int exp_err = 0;

    instr_encoder #(.CNT_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .func3       (func3),
        .func7       (func7),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .immediate   (immediate),
        .shamt       (shamt),
        .instr_type  (instr_type),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .instruction (instruction),
        .imm_err     (imm_err),
        .enc_count   (enc_count),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    function automatic enc_fields_t mk(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [6:0] f7, input logic [4:0] d,
                                       input logic [4:0] s1, input logic [4:0] s2,
                                       input logic [31:0] im, input logic [5:0] sh,
                                       input logic [3:0] t);
        enc_fields_t f;
        f.opcode = op; f.func3 = f3; f.func7 = f7; f.rd = d; f.rs1 = s1;
        f.rs2 = s2; f.imm = im; f.shamt = sh; f.itype = t;
        return f;
    endfunction

    task automatic drive(input enc_fields_t f);
        opcode = f.opcode; func3 = f.func3; func7 = f.func7; rd = f.rd;
        rs1 = f.rs1; rs2 = f.rs2; immediate = f.imm; shamt = f.shamt;
        instr_type = f.itype;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive(mk(7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 6'd0, TYPE_NO));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (instruction !== 32'h0) begin n_bad++; $display("FAIL rst_instruction: got %h want 00000000", instruction); end
        n_cmp++; if (imm_err !== 1'b0) begin n_bad++; $display("FAIL rst_imm_err: got %b want 0", imm_err); end
        n_cmp++; if (enc_count !== 32'd0 || err_count !== 32'd0) begin n_bad++; $display("FAIL rst_counts: got %0d/%0d want 0/0", enc_count, err_count); end
    endtask

    task automatic test_latency();
        @(posedge clk); #1;
        drive(mk(OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 6'd0, TYPE_I));
        in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lat_early: got %b want 0", out_valid); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL lat_valid: got %b want 1", out_valid); end
        n_cmp++; if (instruction !== 32'h00500093 || imm_err !== 1'b0) begin n_bad++; $display("FAIL lat_addi: got %h/%b want 00500093/0", instruction, imm_err); end
        @(posedge clk); exp_enc++;
        @(negedge clk);
        n_cmp++; if (enc_count !== 32'(exp_enc)) begin n_bad++; $display("FAIL lat_enc_count: got %0d want %0d", enc_count, exp_enc); end
    endtask

    task automatic test_formats();
        enc_fields_t v [16];
        logic [31:0] w [16];
        logic        e [16];
        logic        got;
        v[0]  = mk(OP_JAL,    3'd0, 7'd0,       5'd1, 5'd0, 5'd0, 32'd16,        6'd0,  TYPE_UJ); w[0]  = 32'h010000EF; e[0]  = 1'b0;
        v[1]  = mk(OP_LUI,    3'd0, 7'd0,       5'd5, 5'd0, 5'd0, 32'h12345000,  6'd0,  TYPE_U);  w[1]  = 32'h123452B7; e[1]  = 1'b0;
        v[2]  = mk(OP_BRANCH, 3'd0, 7'd0,       5'd0, 5'd1, 5'd2, 32'd3,         6'd0,  TYPE_SB); w[2]  = NOP_WORD;     e[2]  = 1'b1;
        v[3]  = mk(OP_IMM,    3'd0, 7'd0,       5'd1, 5'd0, 5'd0, 32'd2048,      6'd0,  TYPE_I);  w[3]  = NOP_WORD;     e[3]  = 1'b1;
        v[4]  = mk(OP_BRANCH, 3'd0, 7'd0,       5'd0, 5'd1, 5'd2, 32'hFFFFFFFC,  6'd0,  TYPE_SB); w[4]  = 32'hFE208EE3; e[4]  = 1'b0;
        v[5]  = mk(OP_IMM,    3'd1, 7'd0,       5'd1, 5'd2, 5'd0, 32'd0,         6'd40, TYPE_I);  w[5]  = 32'h02811093; e[5]  = 1'b0;
        v[6]  = mk(OP_IMM,    3'd5, 7'b0100000, 5'd1, 5'd2, 5'd0, 32'd0,         6'd3,  TYPE_I);  w[6]  = 32'h40315093; e[6]  = 1'b0;
        v[7]  = mk(OP_IMM32,  3'd5, 7'b0100000, 5'd1, 5'd2, 5'd0, 32'd0,         6'd32, TYPE_I);  w[7]  = NOP_WORD;     e[7]  = 1'b1;
        v[8]  = mk(OP_IMM,    3'd0, 7'd0,       5'd1, 5'd0, 5'd0, 32'hFFFFF800,  6'd0,  TYPE_I);  w[8]  = 32'h80000093; e[8]  = 1'b0;
        v[9]  = mk(OP_IMM,    3'd0, 7'd0,       5'd1, 5'd0, 5'd0, 32'd2047,      6'd0,  TYPE_I);  w[9]  = 32'h7FF00093; e[9]  = 1'b0;
        v[10] = mk(OP_LUI,    3'd0, 7'd0,       5'd5, 5'd0, 5'd0, 32'h12345001,  6'd0,  TYPE_U);  w[10] = NOP_WORD;     e[10] = 1'b1;
        v[11] = mk(OP_IMM,    3'd0, 7'd0,       5'd1, 5'd0, 5'd0, 32'd5,         6'd0,  TYPE_NO); w[11] = NOP_WORD;     e[11] = 1'b1;
        v[12] = mk(OP_JAL,    3'd0, 7'd0,       5'd1, 5'd0, 5'd0, 32'h00100000,  6'd0,  TYPE_UJ); w[12] = NOP_WORD;     e[12] = 1'b1;
        v[13] = mk(OP_JAL,    3'd0, 7'd0,       5'd0, 5'd0, 5'd0, 32'hFFF00000,  6'd0,  TYPE_UJ); w[13] = 32'h8000006F; e[13] = 1'b0;
        v[14] = mk(OP_BRANCH, 3'd0, 7'd0,       5'd0, 5'd0, 5'd0, 32'd4094,      6'd0,  TYPE_SB); w[14] = 32'h7E000FE3; e[14] = 1'b0;
        v[15] = mk(OP_IMM,    3'd0, 7'd0,       5'd1, 5'd0, 5'd0, 32'd5,         6'd0,  4'd9);    w[15] = NOP_WORD;     e[15] = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            drive(v[i]);
            in_valid = 1'b1;
            @(posedge clk); #1 in_valid = 1'b0;
            got = 1'b0;
            for (int k = 0; k < 5 && !got; k++) begin
                @(negedge clk);
                if (out_valid === 1'b1) got = 1'b1;
            end
            n_cmp++;
            if (!got) begin
                n_bad++; $display("FAIL fmt%0d_timeout: got no out_valid want out_valid=1", i);
            end else begin
                if (instruction !== w[i] || imm_err !== e[i]) begin
                    n_bad++; $display("FAIL fmt%0d_word: got %h/%b want %h/%b", i, instruction, imm_err, w[i], e[i]);
                end
                @(posedge clk);
                exp_enc++;
                if (e[i]) exp_err++;
                @(negedge clk);
                n_cmp++;
                if (enc_count !== 32'(exp_enc) || err_count !== 32'(exp_err)) begin
                    n_bad++; $display("FAIL fmt%0d_counts: got %0d/%0d want %0d/%0d", i, enc_count, err_count, exp_enc, exp_err);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        @(posedge clk); #1;
        drive(mk(OP_REG, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 6'd0, TYPE_R));
        in_valid = 1'b1;
        @(posedge clk); #1;
        drive(mk(OP_STORE, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 6'd0, TYPE_S));
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || instruction !== 32'h002081B3) begin n_bad++; $display("FAIL b2b_add: got %b/%h want 1/002081b3", out_valid, instruction); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || instruction !== 32'h0020A423) begin n_bad++; $display("FAIL b2b_sw: got %b/%h want 1/0020a423", out_valid, instruction); end
        @(negedge clk);
        exp_enc += 2;
        n_cmp++; if (enc_count !== 32'(exp_enc) || out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_count: got %0d/%b want %0d/0", enc_count, out_valid, exp_enc); end
    endtask

    task automatic test_backpressure();
        logic [31:0] w [3];
        int          idx;
        logic        acc;
        w[0] = 32'h00100093; w[1] = 32'h00200113; w[2] = 32'h00300193;
        out_ready = 1'b0;
        @(posedge clk); #1;
        drive(mk(OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1, 6'd0, TYPE_I));
        in_valid = 1'b1;
        @(posedge clk); #1;
        drive(mk(OP_IMM, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd2, 6'd0, TYPE_I));
        @(posedge clk); #1;
        drive(mk(OP_IMM, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd3, 6'd0, TYPE_I));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || instruction !== w[0]) begin
                n_bad++; $display("FAIL bp_hold%0d: got rdy=%b vld=%b %h want rdy=0 vld=1 %h", k, in_ready, out_valid, instruction, w[0]);
            end
        end
        @(posedge clk); #1 out_ready = 1'b1;
        idx = 0;
        for (int k = 0; k < 10 && idx < 3; k++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (out_valid === 1'b1) begin
                n_cmp++;
                if (instruction !== w[idx]) begin
                    n_bad++; $display("FAIL bp_order%0d: got %h want %h", idx, instruction, w[idx]);
                end
                idx++;
            end
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
        end
        exp_enc += idx;
        @(negedge clk);
        n_cmp++; if (idx != 3 || out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_total: got %0d words vld=%b want 3 words vld=0", idx, out_valid); end
        n_cmp++; if (enc_count !== 32'(exp_enc)) begin n_bad++; $display("FAIL bp_enc_count: got %0d want %0d", enc_count, exp_enc); end
    endtask

    task automatic test_reset_inflight();
        logic got;
        out_ready = 1'b0;
        @(posedge clk); #1;
        drive(mk(OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 6'd0, TYPE_I));
        in_valid = 1'b1;
        @(posedge clk); #1;
        drive(mk(OP_IMM, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd2, 6'd0, TYPE_I));
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || imm_err !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL rif_full: got vld=%b err=%b rdy=%b want 1/1/0", out_valid, imm_err, in_ready); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || imm_err !== 1'b0 || instruction !== 32'h0) begin n_bad++; $display("FAIL rif_out: got vld=%b err=%b %h want 0/0/00000000", out_valid, imm_err, instruction); end
        n_cmp++; if (enc_count !== 32'd0 || err_count !== 32'd0) begin n_bad++; $display("FAIL rif_counts: got %0d/%0d want 0/0", enc_count, err_count); end
        exp_enc = 0; exp_err = 0;
        @(posedge clk); #1 reset = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL rif_after: got rdy=%b vld=%b want 1/0", in_ready, out_valid); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rif_dropped: got vld=%b want 0", out_valid); end
        @(posedge clk); #1;
        drive(mk(OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 6'd0, TYPE_I));
        in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 5 && !got; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) got = 1'b1;
        end
        n_cmp++; if (!got || instruction !== 32'h00500093 || imm_err !== 1'b0) begin n_bad++; $display("FAIL rif_next: got vld=%b %h/%b want 1 00500093/0", got, instruction, imm_err); end
        @(negedge clk);
        n_cmp++; if (enc_count !== 32'd1 || err_count !== 32'd0) begin n_bad++; $display("FAIL rif_next_count: got %0d/%0d want 1/0", enc_count, err_count); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_formats();
        test_back_to_back();
        test_backpressure();
        test_reset_inflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want completion before 200000");
        $fatal(1, "timeout");
    end

endmodule
